// File: rtl/rram_seq_pkg.sv
// Shared types for the RRAM operation sequencer: operation and state enums
// plus the two-bit line level codes {IN1,IN0}.
package rram_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_SET   = 2'd1,
    OP_RESET = 2'd2,
    OP_MAC   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_DRIVE,
    S_SENSE,
    S_CONVERT,
    S_RECOVER,
    S_DONE
  } state_t;

  localparam logic [1:0] LC_GND   = 2'b00;
  localparam logic [1:0] LC_READ  = 2'b01;
  localparam logic [1:0] LC_WRITE = 2'b10;

endpackage

// File: rtl/rram_line_encoder.sv
// Combinational line-code generator: maps the latched operation, row and
// column mask to per-line {IN1,IN0} levels while the array is being driven.
module rram_line_encoder
  import rram_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [$clog2(N)-1:0] row,
  input  logic [N-1:0]         colmask,
  input  op_t                  op,
  input  logic                 drive,
  output logic [N-1:0]         in0_wl,
  output logic [N-1:0]         in1_wl,
  output logic [N-1:0]         in0_bl,
  output logic [N-1:0]         in1_bl,
  output logic [N-1:0]         in0_sl,
  output logic [N-1:0]         in1_sl
);

  logic [N-1:0] row_hot;
  logic [1:0]   wl_code;
  logic [1:0]   bl_code;
  logic [1:0]   sl_code;

  assign row_hot = {{(N-1){1'b0}}, 1'b1} << row;

  // Every unselected line stays grounded; code 11 can never be produced.
  always_comb begin
    wl_code = LC_GND;
    bl_code = LC_GND;
    sl_code = LC_GND;
    if (drive) begin
      wl_code = (op == OP_READ || op == OP_MAC) ? LC_READ : LC_WRITE;
      if (op == OP_SET)   bl_code = LC_WRITE;
      if (op == OP_RESET) sl_code = LC_WRITE;
    end
    in0_wl = row_hot & {N{wl_code[0]}};
    in1_wl = row_hot & {N{wl_code[1]}};
    in0_bl = colmask & {N{bl_code[0]}};
    in1_bl = colmask & {N{bl_code[1]}};
    in0_sl = colmask & {N{sl_code[0]}};
    in1_sl = colmask & {N{sl_code[1]}};
  end

endmodule

// File: rtl/rram_op_sequencer.sv
// RRAM array operation sequencer (READ / SET / RESET / MAC) with registered
// driver, sense and ADC controls. MAC support is enabled by RRAM_SEQ_MAC_EN.
module rram_op_sequencer
  import rram_seq_pkg::*;
#(
  parameter int ARRAY_SIZE   = 16,
  parameter int PRE_CYCLES   = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int ADC_CYCLES   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [1:0]                     op_type,
  input  logic [$clog2(ARRAY_SIZE)-1:0]  op_row,
  input  logic [ARRAY_SIZE-1:0]          op_colmask,
  output logic                           ENABLE_WL,
  output logic                           ENABLE_BL,
  output logic                           ENABLE_SL,
  output logic [ARRAY_SIZE-1:0]          IN0_WL,
  output logic [ARRAY_SIZE-1:0]          IN1_WL,
  output logic [ARRAY_SIZE-1:0]          IN0_BL,
  output logic [ARRAY_SIZE-1:0]          IN1_BL,
  output logic [ARRAY_SIZE-1:0]          IN0_SL,
  output logic [ARRAY_SIZE-1:0]          IN1_SL,
  output logic                           PRE,
  output logic                           ENABLE_CSA,
  output logic                           SAEN_CSA,
  input  logic [ARRAY_SIZE-1:0]          CSA,
  output logic                           ENABLE_ADC,
  output logic [1:0]                     CLK_EN_ADC,
  input  logic [ARRAY_SIZE-1:0]          ADC_OUT0,
  input  logic [ARRAY_SIZE-1:0]          ADC_OUT1,
  input  logic [ARRAY_SIZE-1:0]          ADC_OUT2,
  output logic [3*ARRAY_SIZE-1:0]        result,
  output logic                           result_valid,
  output logic                           op_err
);

  localparam int N     = ARRAY_SIZE;
  localparam int CNT_W = 16;

  state_t               state;
  op_t                  op_q;
  logic [$clog2(N)-1:0] row_q;
  logic [N-1:0]         mask_q;
  logic [CNT_W-1:0]     cnt;
  logic                 err_q;
  logic [3*N-1:0]       res_q;
  logic                 accept;
  logic [N-1:0]         enc_in0_wl, enc_in1_wl, enc_in0_bl;
  logic [N-1:0]         enc_in1_bl, enc_in0_sl, enc_in1_sl;

  assign accept = op_valid && op_ready;

  rram_line_encoder #(.N(N)) u_enc (
    .row     (row_q),
    .colmask (mask_q),
    .op      (op_q),
    .drive   (state == S_DRIVE),
    .in0_wl  (enc_in0_wl),
    .in1_wl  (enc_in1_wl),
    .in0_bl  (enc_in0_bl),
    .in1_bl  (enc_in1_bl),
    .in0_sl  (enc_in0_sl),
    .in1_sl  (enc_in1_sl)
  );

  // Control outputs are registered from the current state, so they trail the
  // state by one cycle; op_ready instead tracks the state being entered so a
  // request can never be accepted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_READ;
      row_q        <= '0;
      mask_q       <= '0;
      cnt          <= '0;
      err_q        <= 1'b0;
      res_q        <= '0;
      op_ready     <= 1'b1;
      ENABLE_WL    <= 1'b0;
      ENABLE_BL    <= 1'b0;
      ENABLE_SL    <= 1'b0;
      IN0_WL       <= '0;
      IN1_WL       <= '0;
      IN0_BL       <= '0;
      IN1_BL       <= '0;
      IN0_SL       <= '0;
      IN1_SL       <= '0;
      PRE          <= 1'b0;
      ENABLE_CSA   <= 1'b0;
      SAEN_CSA     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      op_err       <= 1'b0;
    end else begin
      op_ready     <= (state == S_DONE) || (state == S_IDLE && !accept);
      PRE          <= (state == S_PRECHARGE);
      ENABLE_WL    <= (state == S_DRIVE);
      ENABLE_BL    <= (state == S_DRIVE);
      ENABLE_SL    <= (state == S_DRIVE);
      IN0_WL       <= enc_in0_wl;
      IN1_WL       <= enc_in1_wl;
      IN0_BL       <= enc_in0_bl;
      IN1_BL       <= enc_in1_bl;
      IN0_SL       <= enc_in0_sl;
      IN1_SL       <= enc_in1_sl;
      ENABLE_CSA   <= (op_q == OP_READ) && (state == S_DRIVE || state == S_SENSE);
      SAEN_CSA     <= (state == S_SENSE);
      result_valid <= (state == S_DONE) && !err_q;
      op_err       <= (state == S_DONE) && err_q;
      if (state == S_DONE && !err_q) result <= res_q;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op_t'(op_type);
            row_q  <= op_row;
            mask_q <= op_colmask;
            err_q  <= 1'b0;
            case (op_t'(op_type))
              OP_READ: begin
                state <= S_PRECHARGE;
                cnt   <= CNT_W'(PRE_CYCLES - 1);
              end
              OP_MAC: begin
`ifdef RRAM_SEQ_MAC_EN
                state <= S_PRECHARGE;
                cnt   <= CNT_W'(PRE_CYCLES - 1);
`else
                state <= S_DONE;
                err_q <= 1'b1;
`endif
              end
              default: begin
                state <= S_DRIVE;
                cnt   <= CNT_W'(PULSE_CYCLES - 1);
              end
            endcase
          end
        end
        S_PRECHARGE: begin
          if (cnt == '0) begin
            state <= S_DRIVE;
            cnt   <= CNT_W'(PULSE_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == '0) begin
            case (op_q)
              OP_READ: state <= S_SENSE;
              OP_MAC: begin
`ifdef RRAM_SEQ_MAC_EN
                state <= S_CONVERT;
                cnt   <= CNT_W'(ADC_CYCLES - 1);
`else
                state <= S_DONE;
`endif
              end
              default: state <= S_RECOVER;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SENSE: begin
          res_q <= {{(2*N){1'b0}}, CSA & mask_q};
          state <= S_DONE;
        end
`ifdef RRAM_SEQ_MAC_EN
        S_CONVERT: begin
          if (cnt == '0) begin
            res_q <= {ADC_OUT2, ADC_OUT1, ADC_OUT0};
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_RECOVER: begin
          res_q <= '0;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RRAM_SEQ_MAC_EN
  // The ADC clock runs through the whole conversion; the second phase marks
  // the final conversion cycle so the converter can latch its outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ENABLE_ADC <= 1'b0;
      CLK_EN_ADC <= 2'b00;
    end else begin
      ENABLE_ADC <= (op_q == OP_MAC) && (state == S_DRIVE || state == S_CONVERT);
      CLK_EN_ADC <= {(state == S_CONVERT) && (cnt == '0), (state == S_CONVERT)};
    end
  end
`else
  logic unused_adc;
  assign unused_adc = (^{ADC_OUT2, ADC_OUT1, ADC_OUT0}) ^ (ADC_CYCLES > 0);
  assign ENABLE_ADC = 1'b0;
  assign CLK_EN_ADC = 2'b00;
`endif

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Directed self-checking bench for rram_op_sequencer; the MAC scenario
// follows RRAM_SEQ_MAC_EN.
module tb_rram_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [3:0]  op_row;
  logic [15:0] op_colmask;
  logic        ENABLE_WL, ENABLE_BL, ENABLE_SL;
  logic [15:0] IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL;
  logic        PRE, ENABLE_CSA, SAEN_CSA;
  logic [15:0] CSA;
  logic        ENABLE_ADC;
  logic [1:0]  CLK_EN_ADC;
  logic [15:0] ADC_OUT0, ADC_OUT1, ADC_OUT2;
  logic [47:0] result;
  logic        result_valid;
  logic        op_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rram_op_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .op_row(op_row), .op_colmask(op_colmask),
    .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
    .IN0_WL(IN0_WL), .IN1_WL(IN1_WL), .IN0_BL(IN0_BL), .IN1_BL(IN1_BL),
    .IN0_SL(IN0_SL), .IN1_SL(IN1_SL), .PRE(PRE), .ENABLE_CSA(ENABLE_CSA),
    .SAEN_CSA(SAEN_CSA), .CSA(CSA), .ENABLE_ADC(ENABLE_ADC),
    .CLK_EN_ADC(CLK_EN_ADC), .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1),
    .ADC_OUT2(ADC_OUT2), .result(result), .result_valid(result_valid),
    .op_err(op_err)
  );

  // Waits (bounded) for IDLE, presents one request and returns 1 ns after
  // the accepting edge t0.
  task automatic start_op(input logic [1:0] t, input logic [3:0] r, input logic [15:0] m);
    int waited = 0;
    @(negedge clk);
    while (!op_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!op_ready) begin
      miscompares++;
      $display("[TB] FAIL start_ready got %b want 1", op_ready);
    end
    op_type = t; op_row = r; op_colmask = m; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", op_ready); end
    vectors++;
    if (result !== 48'h0) begin miscompares++; $display("[TB] FAIL reset_result got %h want 0", result); end
    vectors++;
    if ({IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL} !== 96'h0) begin
      miscompares++; $display("[TB] FAIL reset_codes got nonzero line codes");
    end
    vectors++;
    if ({ENABLE_WL, ENABLE_BL, ENABLE_SL, PRE, ENABLE_CSA, SAEN_CSA, ENABLE_ADC, CLK_EN_ADC,
         result_valid, op_err} !== 11'b0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl got nonzero control outputs");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read(input logic [3:0] r, input logic [15:0] m, input logic [15:0] csa_val);
    logic [15:0] exp_wl;
    logic [47:0] exp_res;
    exp_wl  = 16'h0001 << r;
    exp_res = {32'h0, csa_val & m};
    CSA = csa_val;
    start_op(2'd0, r, m);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (PRE !== (k <= 2)) begin miscompares++; $display("[TB] FAIL read_pre k=%0d got %b want %b", k, PRE, (k <= 2)); end
      vectors++;
      if (IN0_WL !== ((k >= 3 && k <= 6) ? exp_wl : 16'h0)) begin
        miscompares++; $display("[TB] FAIL read_in0_wl k=%0d got %h", k, IN0_WL);
      end
      vectors++;
      if ({IN1_WL, IN1_BL, IN1_SL} !== 48'h0) begin miscompares++; $display("[TB] FAIL read_in1 k=%0d got nonzero", k); end
      vectors++;
      if (ENABLE_WL !== (k >= 3 && k <= 6)) begin miscompares++; $display("[TB] FAIL read_en_wl k=%0d got %b", k, ENABLE_WL); end
      vectors++;
      if (ENABLE_CSA !== (k >= 3 && k <= 7)) begin miscompares++; $display("[TB] FAIL read_en_csa k=%0d got %b", k, ENABLE_CSA); end
      vectors++;
      if (SAEN_CSA !== (k == 7)) begin miscompares++; $display("[TB] FAIL read_saen k=%0d got %b", k, SAEN_CSA); end
      vectors++;
      if (result_valid !== (k == 8)) begin miscompares++; $display("[TB] FAIL read_valid k=%0d got %b", k, result_valid); end
      vectors++;
      if (op_ready !== (k >= 8)) begin miscompares++; $display("[TB] FAIL read_ready k=%0d got %b", k, op_ready); end
      if (k >= 8) begin
        vectors++;
        if (result !== exp_res) begin miscompares++; $display("[TB] FAIL read_result k=%0d got %h want %h", k, result, exp_res); end
      end
    end
  endtask

  task automatic test_set();
    start_op(2'd1, 4'd1, 16'h0003);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (IN1_WL !== ((k <= 4) ? 16'h0002 : 16'h0)) begin miscompares++; $display("[TB] FAIL set_in1_wl k=%0d got %h", k, IN1_WL); end
      vectors++;
      if (IN1_BL !== ((k <= 4) ? 16'h0003 : 16'h0)) begin miscompares++; $display("[TB] FAIL set_in1_bl k=%0d got %h", k, IN1_BL); end
      vectors++;
      if ({IN0_WL, IN0_BL, IN0_SL, IN1_SL} !== 64'h0) begin miscompares++; $display("[TB] FAIL set_other_codes k=%0d got nonzero", k); end
      vectors++;
      if (ENABLE_BL !== (k <= 4)) begin miscompares++; $display("[TB] FAIL set_en_bl k=%0d got %b", k, ENABLE_BL); end
      vectors++;
      if ({PRE, ENABLE_CSA, SAEN_CSA} !== 3'b0) begin miscompares++; $display("[TB] FAIL set_sense_ctrl k=%0d got %b", k, {PRE, ENABLE_CSA, SAEN_CSA}); end
      vectors++;
      if (result_valid !== (k == 6)) begin miscompares++; $display("[TB] FAIL set_valid k=%0d got %b", k, result_valid); end
      if (k >= 6) begin
        vectors++;
        if (result !== 48'h0) begin miscompares++; $display("[TB] FAIL set_result k=%0d got %h want 0", k, result); end
      end
    end
  endtask

`ifdef RRAM_SEQ_MAC_EN
  task automatic test_mac();
    logic [1:0] exp_clk;
    ADC_OUT2 = 16'd3; ADC_OUT1 = 16'd2; ADC_OUT0 = 16'd1;
    start_op(2'd3, 4'd2, 16'hFFFF);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      exp_clk = (k == 7 || k == 8) ? 2'b01 : (k == 9) ? 2'b11 : 2'b00;
      vectors++;
      if (CLK_EN_ADC !== exp_clk) begin miscompares++; $display("[TB] FAIL mac_clk_en k=%0d got %b want %b", k, CLK_EN_ADC, exp_clk); end
      vectors++;
      if (ENABLE_ADC !== (k >= 3 && k <= 9)) begin miscompares++; $display("[TB] FAIL mac_en_adc k=%0d got %b", k, ENABLE_ADC); end
      vectors++;
      if (IN0_WL !== ((k >= 3 && k <= 6) ? 16'h0004 : 16'h0)) begin miscompares++; $display("[TB] FAIL mac_in0_wl k=%0d got %h", k, IN0_WL); end
      vectors++;
      if (result_valid !== (k == 10)) begin miscompares++; $display("[TB] FAIL mac_valid k=%0d got %b", k, result_valid); end
      if (k >= 10) begin
        vectors++;
        if (result !== 48'h0003_0002_0001) begin miscompares++; $display("[TB] FAIL mac_result k=%0d got %h", k, result); end
      end
    end
  endtask
`else
  task automatic test_mac();
    logic [47:0] prior;
    prior = result;
    start_op(2'd3, 4'd2, 16'hFFFF);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (op_err !== (k == 1)) begin miscompares++; $display("[TB] FAIL mac_err k=%0d got %b", k, op_err); end
      vectors++;
      if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mac_valid k=%0d got %b want 0", k, result_valid); end
      vectors++;
      if (result !== prior) begin miscompares++; $display("[TB] FAIL mac_result k=%0d got %h want %h", k, result, prior); end
      vectors++;
      if ({ENABLE_ADC, CLK_EN_ADC, ENABLE_WL, ENABLE_BL, ENABLE_SL, PRE, ENABLE_CSA, SAEN_CSA} !== 9'b0) begin
        miscompares++; $display("[TB] FAIL mac_enables k=%0d got nonzero", k);
      end
      vectors++;
      if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mac_ready k=%0d got %b", k, op_ready); end
    end
  endtask
`endif

  task automatic test_reset_mid_drive();
    start_op(2'd2, 4'd2, 16'hF0F0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (IN1_SL !== 16'hF0F0) begin miscompares++; $display("[TB] FAIL rmd_in1_sl got %h want f0f0", IN1_SL); end
    vectors++;
    if (IN1_WL !== 16'h0004) begin miscompares++; $display("[TB] FAIL rmd_in1_wl got %h want 0004", IN1_WL); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL} !== 96'h0) begin
      miscompares++; $display("[TB] FAIL rmd_codes got nonzero line codes");
    end
    vectors++;
    if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmd_ready got %b want 1", op_ready); end
    vectors++;
    if ({ENABLE_WL, ENABLE_BL, ENABLE_SL} !== 3'b0) begin miscompares++; $display("[TB] FAIL rmd_enables got %b", {ENABLE_WL, ENABLE_BL, ENABLE_SL}); end
    @(negedge clk);
    rst = 1'b0;
    test_read(4'd9, 16'h0F0F, 16'h3C3C);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int rv[$];
    @(negedge clk);
    op_type = 2'd1; op_row = 4'd3; op_colmask = 16'h00F0; op_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (op_ready) acc.push_back(i);
      if (result_valid) rv.push_back(i);
      @(negedge clk);
    end
    op_valid = 1'b0;
    vectors++;
    if (acc.size() != 3) begin miscompares++; $display("[TB] FAIL b2b_accepts got %0d want 3", acc.size()); end
    if (acc.size() == 3 && rv.size() >= 1) begin
      vectors++;
      if (acc[1] - acc[0] != 7) begin miscompares++; $display("[TB] FAIL b2b_gap1 got %0d want 7", acc[1] - acc[0]); end
      vectors++;
      if (acc[2] - acc[1] != 7) begin miscompares++; $display("[TB] FAIL b2b_gap2 got %0d want 7", acc[2] - acc[1]); end
      vectors++;
      if (rv[0] != acc[1]) begin miscompares++; $display("[TB] FAIL b2b_after_done got %0d want %0d", acc[1], rv[0]); end
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL b2b_sequence got %0d accepts %0d results", acc.size(), rv.size());
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_type = 2'd0; op_row = 4'd0; op_colmask = 16'h0;
    CSA = 16'h0; ADC_OUT0 = 16'h0; ADC_OUT1 = 16'h0; ADC_OUT2 = 16'h0;
    test_reset();
    test_read(4'd5, 16'h00FF, 16'hA5A5);
    test_mac();
    test_set();
    test_reset_mid_drive();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
